btn_cmd_sched: RTL and testbench

//  Sits between the four debounce instances (left, right, fire, center) and the game FSM.

---
 rtl/btn_cmd_sched.sv | 147 ++++++++++++++
 tb/tb_btn_cmd_sched.sv | 258 +++++++++++++++++++++++++
 2 files changed

// File: rtl/btn_cmd_sched.sv
// Button command scheduler: latches debounced presses, auto-repeats held left/right, rate-limits fire,
// tracks pause, and offers one command at a time over valid/ready. Define PAUSE_LOCK_EN to lock bits 0..2 while paused.
module btn_cmd_sched #(
  parameter int REP_DLY = 25_000_000,
  parameter int REP_PER = 10_000_000,
  parameter int FIRE_CD = 20_000_000,
  parameter int CNT_W   = 25
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [3:0] btn_clean,
  input  logic [3:0] btn_single,
  input  logic       cmd_ready,
  output logic       cmd_valid,
  output logic [1:0] cmd_id,
  output logic [3:0] pending,
  output logic       paused
);

  typedef enum logic {IDLE, OFFER} state_t;

  localparam logic [CNT_W-1:0] DLY_LIM  = CNT_W'(REP_DLY - 1);
  localparam logic [CNT_W-1:0] PER_LIM  = CNT_W'(REP_PER - 1);
  localparam logic [CNT_W-1:0] FIRE_LIM = CNT_W'(FIRE_CD - 1);

  state_t           state_q, state_d;
  logic [1:0]       ptr_q, ptr_d, id_d, pick;
  logic             valid_d, pick_ok, grant, lock, fire_cool;
  logic [1:0]       rep_evt;
  logic [3:0]       set_vec, clr_vec, elig, pend_d;
  logic [CNT_W-1:0] fire_cnt;

`ifdef PAUSE_LOCK_EN
  assign lock = paused;
`else
  assign lock = 1'b0;
`endif

  assign grant     = (state_q == OFFER) & cmd_ready;
  assign fire_cool = (fire_cnt != '0);

  // Auto-repeat for left/right: a delay phase first, then fixed-period phase while held.
  for (genvar i = 0; i < 2; i++) begin : g_rep
    logic [CNT_W-1:0] cnt;
    logic             phase;
    logic [CNT_W-1:0] lim;

    assign lim        = phase ? PER_LIM : DLY_LIM;
    assign rep_evt[i] = btn_clean[i] & ~lock & (cnt == lim);

    // NOTE: state registers use non-blocking assignments and reset asynchronously so every flop
    // clears the moment rst_n falls, independent of the clock.
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        cnt   <= '0;
        phase <= 1'b0;
      end else if (!btn_clean[i] || lock) begin
        cnt   <= '0;
        phase <= 1'b0;
      end else if (rep_evt[i]) begin
        cnt   <= '0;
        phase <= 1'b1;
      end else begin
        cnt <= cnt + 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                       fire_cnt <= '0;
    else if (grant && cmd_id == 2'd2) fire_cnt <= FIRE_LIM;
    else if (fire_cool)               fire_cnt <= fire_cnt - 1'b1;
  end

  // NOTE: every variable driven here gets a default first, so no path can infer a latch.
  always_comb begin
    set_vec      = btn_single;
    set_vec[1:0] = set_vec[1:0] | rep_evt;
    if (fire_cool) set_vec[2] = 1'b0;
    if (lock)      set_vec[2:0] = '0;

    clr_vec = '0;
    if (grant) clr_vec[cmd_id] = 1'b1;
    // A set in the same cycle as the grant-clear wins.
    pend_d = (pending & ~clr_vec) | set_vec;
    if (lock) pend_d[2:0] = '0;

    elig = pending;
    if (fire_cool) elig[2] = 1'b0;
    if (lock)      elig[2:0] = '0;
  end

  // Round-robin pick: ptr+1 has highest priority, ptr itself the lowest.
  always_comb begin
    pick    = '0;
    pick_ok = 1'b0;
    for (int k = 4; k >= 1; k--) begin
      if (elig[ptr_q + 2'(k)]) begin
        pick    = ptr_q + 2'(k);
        pick_ok = 1'b1;
      end
    end
  end

  always_comb begin
    state_d = state_q;
    valid_d = cmd_valid;
    id_d    = cmd_id;
    ptr_d   = ptr_q;
    unique case (state_q)
      IDLE: begin
        if (pick_ok) begin
          state_d = OFFER;
          valid_d = 1'b1;
          id_d    = pick;
        end
      end
      OFFER: begin
        if (cmd_ready) begin
          state_d = IDLE;
          valid_d = 1'b0;
          ptr_d   = cmd_id;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      cmd_valid <= 1'b0;
      cmd_id    <= 2'd0;
      ptr_q     <= 2'd3;
      pending   <= '0;
      paused    <= 1'b0;
    end else begin
      state_q   <= state_d;
      cmd_valid <= valid_d;
      cmd_id    <= id_d;
      ptr_q     <= ptr_d;
      pending   <= pend_d;
      if (grant && cmd_id == 2'd3) paused <= ~paused;
    end
  end

endmodule

// File: tb/tb_btn_cmd_sched.sv
// Scoreboard bench for btn_cmd_sched: a timestamp-based reference model predicts offers; a negedge monitor
// compares handshakes, pending and pause state. Directed scenarios followed by randomized traffic.
module tb_btn_cmd_sched;

  localparam int REP_DLY = 8;
  localparam int REP_PER = 4;
  localparam int FIRE_CD = 10;
  localparam int CNT_W   = 8;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [3:0] btn_clean = '0;
  logic [3:0] btn_single = '0;
  logic       cmd_ready = 1'b0;
  logic       cmd_valid;
  logic [1:0] cmd_id;
  logic [3:0] pending;
  logic       paused;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  btn_cmd_sched #(
    .REP_DLY(REP_DLY), .REP_PER(REP_PER), .FIRE_CD(FIRE_CD), .CNT_W(CNT_W)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .btn_clean (btn_clean),
    .btn_single(btn_single),
    .cmd_ready (cmd_ready),
    .cmd_valid (cmd_valid),
    .cmd_id    (cmd_id),
    .pending   (pending),
    .paused    (paused)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: edge counter, press-hold lengths, time of last fire grant, and the command on offer.
  bit [3:0] m_pend;
  int       m_offer;
  int       m_ptr;
  bit       m_paused;
  int       held [2];
  longint   cyc;
  longint   last_fire;
  int       exp_q [$];
  int       grant_log [$];

  task automatic model_reset();
    m_pend    = '0;
    m_offer   = -1;
    m_ptr     = 3;
    m_paused  = 1'b0;
    held[0]   = 0;
    held[1]   = 0;
    last_fire = -1000;
    exp_q.delete();
  endtask

  task automatic model_step();
    bit [3:0] set_v, elig_v;
    bit       locked, cooling, do_grant;
    int       pick;
    cyc++;
`ifdef PAUSE_LOCK_EN
    locked = m_paused;
`else
    locked = 1'b0;
`endif
    cooling  = (cyc - last_fire) < FIRE_CD;
    do_grant = (m_offer >= 0) && cmd_ready;

    set_v = btn_single;
    for (int i = 0; i < 2; i++) begin
      if (btn_clean[i] && !locked) held[i]++;
      else held[i] = 0;
      if (held[i] == REP_DLY || (held[i] > REP_DLY && (held[i] - REP_DLY) % REP_PER == 0))
        set_v[i] = 1'b1;
    end
    if (cooling) set_v[2] = 1'b0;
    if (locked)  set_v[2:0] = '0;

    elig_v = m_pend;
    if (cooling) elig_v[2] = 1'b0;
    if (locked)  elig_v[2:0] = '0;

    if (do_grant) begin
      m_pend[m_offer] = 1'b0;
      m_ptr = m_offer;
      if (m_offer == 3) m_paused = ~m_paused;
      if (m_offer == 2) last_fire = cyc;
      m_offer = -1;
    end else if (m_offer < 0) begin
      pick = -1;
      for (int k = 1; k <= 4; k++)
        if (pick < 0 && elig_v[(m_ptr + k) % 4]) pick = (m_ptr + k) % 4;
      if (pick >= 0) begin
        m_offer = pick;
        exp_q.push_back(pick);
      end
    end
    m_pend = m_pend | set_v;
    if (locked) m_pend[2:0] = '0;
  endtask

  // Monitor: samples on the falling edge, away from the active edge.
  always @(negedge clk) begin
    if (rst_n) begin
      check("valid", cmd_valid, m_offer >= 0);
      check("pending", pending, m_pend);
      check("paused", paused, m_paused);
      if (m_offer >= 0) check("offer_id", cmd_id, m_offer);
      if (cmd_valid && cmd_ready) begin
        grant_log.push_back(int'(cmd_id));
        if (exp_q.size() == 0) begin
          n_checks++;
          n_fail++;
          $display("FAIL sb_grant: got id %0d expected no grant at %0t", cmd_id, $time);
        end else begin
          check("sb_grant_id", cmd_id, exp_q.pop_front());
        end
      end
    end
  end

  task automatic step(input logic [3:0] single, input logic [3:0] clean, input logic rdy);
    btn_single = single;
    btn_clean  = clean;
    cmd_ready  = rdy;
    @(posedge clk);
    if (rst_n) model_step();
    #1;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    btn_single = '0;
    btn_clean  = '0;
    cmd_ready  = 1'b0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    check("rst_valid", cmd_valid, 1'b0);
    check("rst_id", cmd_id, 2'd0);
    check("rst_pending", pending, 4'd0);
    check("rst_paused", paused, 1'b0);
    rst_n = 1'b1;
  endtask

  initial begin
    cyc = 0;
    model_reset();
    do_reset();

    // Single left press: pending next edge, offer the edge after, cleared by ready.
    step(4'b0001, 4'b0000, 1'b0);
    check("t1_pending", pending, 4'b0001);
    check("t1_valid_early", cmd_valid, 1'b0);
    step(4'b0000, 4'b0000, 1'b0);
    check("t1_valid", cmd_valid, 1'b1);
    check("t1_id", cmd_id, 2'd0);
    step(4'b0000, 4'b0000, 1'b1);
    check("t1_cleared", pending, 4'b0000);
    check("t1_valid_off", cmd_valid, 1'b0);

    // All four at once from reset: granted 0,1,2,3 and pause toggles on center.
    do_reset();
    grant_log.delete();
    step(4'b1111, 4'b0000, 1'b0);
    repeat (3) step(4'b0000, 4'b0000, 1'b0);
    repeat (10) step(4'b0000, 4'b0000, 1'b1);
    check("t2_count", grant_log.size(), 4);
    foreach (grant_log[i]) check("t2_order", grant_log[i], i);
    check("t2_paused", paused, 1'b1);

`ifdef PAUSE_LOCK_EN
    // Locked while paused: left/right/fire ignored until center unpauses.
    grant_log.delete();
    step(4'b0111, 4'b0000, 1'b1);
    step(4'b0000, 4'b0000, 1'b1);
    check("t6_locked", pending, 4'b0000);
    step(4'b1000, 4'b0000, 1'b1);
    repeat (3) step(4'b0000, 4'b0000, 1'b1);
    check("t6_unpaused", paused, 1'b0);
    step(4'b0001, 4'b0000, 1'b1);
    repeat (4) step(4'b0000, 4'b0000, 1'b1);
    check("t6_count", grant_log.size(), 2);
    if (grant_log.size() == 2) check("t6_left", grant_log[1], 0);
`endif

    // Held right: press grant, then repeats at 8, 12 and 16 edges of hold; release stops them.
    grant_log.delete();
    step(4'b0010, 4'b0010, 1'b1);
    repeat (17) step(4'b0000, 4'b0010, 1'b1);
    repeat (10) step(4'b0000, 4'b0000, 1'b1);
    check("t3_count", grant_log.size(), 4);
    foreach (grant_log[i]) check("t3_id", grant_log[i], 1);

    // Fire cooldown: second press 3 edges after the grant is dropped, one 12 edges after is granted.
    grant_log.delete();
    step(4'b0100, 4'b0000, 1'b1);
    repeat (4) step(4'b0000, 4'b0000, 1'b1);
    step(4'b0100, 4'b0000, 1'b1);
    check("t4_dropped", pending[2], 1'b0);
    repeat (8) step(4'b0000, 4'b0000, 1'b1);
    step(4'b0100, 4'b0000, 1'b1);
    check("t4_accepted", pending[2], 1'b1);
    repeat (4) step(4'b0000, 4'b0000, 1'b1);
    check("t4_count", grant_log.size(), 2);
    foreach (grant_log[i]) check("t4_id", grant_log[i], 2);

    // Asynchronous reset in the middle of an offer.
    step(4'b1000, 4'b0000, 1'b0);
    step(4'b0000, 4'b0000, 1'b0);
    check("t5_offering", cmd_valid, 1'b1);
    #2;
    rst_n = 1'b0;
    model_reset();
    #1;
    check("t5_valid", cmd_valid, 1'b0);
    check("t5_pending", pending, 4'b0000);
    check("t5_paused", paused, 1'b0);
    repeat (2) step(4'b0000, 4'b0000, 1'b1);
    rst_n = 1'b1;
    grant_log.delete();
    repeat (5) step(4'b0000, 4'b0000, 1'b1);
    check("t5_no_grant", grant_log.size(), 0);

    // Randomized traffic: sparse presses, slowly toggling holds, stuttering ready.
    begin
      logic [3:0] clean_r;
      logic [3:0] single_r;
      clean_r = '0;
      for (int n = 0; n < 3000; n++) begin
        single_r = '0;
        for (int b = 0; b < 4; b++) single_r[b] = ($urandom_range(0, 7) == 0);
        for (int b = 0; b < 2; b++) if ($urandom_range(0, 39) == 0) clean_r[b] = ~clean_r[b];
        step(single_r, clean_r, $urandom_range(0, 2) != 0);
      end
    end
    repeat (40) step(4'b0000, 4'b0000, 1'b1);
    check("drain_queue", exp_q.size(), 0);
    check("drain_valid", cmd_valid, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
